// File: rtl/rom_burst_reader.sv
// Burst read master for a single-port synchronous ROM: issues wrapped read addresses,
// captures the registered ROM output and streams it out through a 4-entry valid/ready buffer.
module rom_burst_reader #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DEPTH_LOG-1:0] start_addr,
    input  logic [DEPTH_LOG:0]   len,
    output logic                 busy,
    output logic                 done,
    output logic [DEPTH_LOG-1:0] rom_addr,
    input  logic [WIDTH-1:0]     rom_data,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready
);

    localparam int BUF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [DEPTH_LOG-1:0]   rom_addr_reg, rom_addr_next;
    logic [1:0]             vld_reg, vld_next;
    logic [DEPTH_LOG:0]     remaining_reg, remaining_next;
    logic [DEPTH_LOG:0]     xfer_reg, xfer_next;
    logic [1:0]             wr_ptr_reg, rd_ptr_reg;
    logic [2:0]             count_reg;
    logic [2:0]             inflight;
    logic                   push;
    logic                   pop;
    logic [BUF_DEPTH-1:0][WIDTH-1:0] entry_word;

    assign push     = vld_reg[1];
    assign m_valid  = (count_reg != 3'd0);
    assign pop      = m_valid && m_ready;
    assign inflight = {2'b00, vld_reg[1]} + {2'b00, vld_reg[0]};

    assign busy     = (state_reg == RUN);
    assign done     = (state_reg == FIN);
    assign rom_addr = rom_addr_reg;
    assign m_data   = m_valid ? entry_word[rd_ptr_reg] : '0;

    // Next-state and read-issue logic; credits count buffered plus in-flight words.
    always_comb begin
        state_next     = state_reg;
        rom_addr_next  = rom_addr_reg;
        vld_next       = {vld_reg[0], 1'b0};
        remaining_next = remaining_reg;
        xfer_next      = pop ? (xfer_reg - (DEPTH_LOG+1)'(1)) : xfer_reg;

        case (state_reg)
            IDLE, FIN: begin
                if (state_reg == FIN) begin
                    state_next = IDLE;
                end
                if (start) begin
                    xfer_next = len;
                    if (len == '0) begin
                        state_next     = FIN;
                        remaining_next = '0;
                    end else begin
                        state_next     = RUN;
                        rom_addr_next  = start_addr;
                        vld_next[0]    = 1'b1;
                        remaining_next = len - (DEPTH_LOG+1)'(1);
                    end
                end
            end
            RUN: begin
                if ((remaining_reg != '0) && ((count_reg + inflight) < 3'd4)) begin
                    rom_addr_next  = rom_addr_reg + DEPTH_LOG'(1);
                    vld_next[0]    = 1'b1;
                    remaining_next = remaining_reg - (DEPTH_LOG+1)'(1);
                end
                if (pop && (xfer_reg == (DEPTH_LOG+1)'(1))) begin
                    state_next = FIN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rom_addr_reg  <= '0;
            vld_reg       <= '0;
            remaining_reg <= '0;
            xfer_reg      <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            rom_addr_reg  <= rom_addr_next;
            vld_reg       <= vld_next;
            remaining_reg <= remaining_next;
            xfer_reg      <= xfer_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Buffer entries; a write and a pop in the same cycle touch different slots.
    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == 2'(gi))) begin
                    entry_reg <= rom_data;
                end
            end
            assign entry_word[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: directed and random bursts checked against a queue model
// of the expected word stream built from the ROM contents and wrapped addresses.
module tb_rom_burst_reader;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int DEPTH_LOG = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [DEPTH_LOG-1:0] start_addr;
    logic [DEPTH_LOG:0]   len;
    logic                 busy;
    logic                 done;
    logic [DEPTH_LOG-1:0] rom_addr;
    logic [WIDTH-1:0]     rom_data;
    logic [WIDTH-1:0]     m_data;
    logic                 m_valid;
    logic                 m_ready;

    logic [WIDTH-1:0] rom_mem [DEPTH];
    int               cyc    = 0;
    int               checks = 0;
    int               errors = 0;
    int               ovf    = 0;
    logic [WIDTH-1:0] got_q[$];
    int               got_edge[$];

    always #5 clk = ~clk;

    rom_burst_reader #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .DEPTH_LOG(DEPTH_LOG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .start_addr(start_addr),
        .len(len),
        .busy(busy),
        .done(done),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready)
    );

    // Synchronous ROM with registered output
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Transfer monitor: records every accepted word and the edge it was taken on
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && m_valid && m_ready) begin
            got_q.push_back(m_data);
            got_edge.push_back(cyc);
        end
        if (dut.count_reg > 3'd4) ovf = ovf + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready high, 1: stall 8 cycles then toggle, 2: random ready, 3: stray start mid-run
    task automatic run_burst(input logic [DEPTH_LOG-1:0] sa, input logic [DEPTH_LOG:0] ln,
                             input int mode, input string tag);
        logic [WIDTH-1:0] exp_q[$];
        int  e0;
        int  fin_edge;
        int  n;
        int  last;
        bit  seen_fin;
        exp_q = {};
        for (int i = 0; i < int'(ln); i++) begin
            exp_q.push_back(rom_mem[(int'(sa) + i) % DEPTH]);
        end
        got_q    = {};
        got_edge = {};
        start_addr = sa;
        len        = ln;
        start      = 1'b1;
        if (mode == 1) m_ready = 1'b0;
        else if (mode == 2) m_ready = 1'($urandom_range(0, 1));
        else m_ready = 1'b1;
        e0 = cyc + 1;
        tick();
        start = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy), 32'(ln != '0));
        if (ln != '0) check({tag, " rom_addr_first"}, 32'(rom_addr), 32'(sa));

        n = 0;
        seen_fin = (done === 1'b1);
        while (!seen_fin && n < 400) begin
            if (mode == 1) m_ready = (n < 8) ? 1'b0 : n[0];
            else if (mode == 2) m_ready = 1'($urandom_range(0, 1));
            else m_ready = 1'b1;
            if (mode == 3 && n == 2) begin
                start      = 1'b1;
                start_addr = 4'(sa + 4'd7);
                len        = 5'd2;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
            if (mode == 1 && n == 8) begin
                check({tag, " stall_rom_addr"}, 32'(rom_addr), 32'(4'(sa + 4'd3)));
                check({tag, " stall_valid"}, 32'(m_valid), 32'd1);
                check({tag, " stall_data"}, 32'(m_data), 32'(exp_q[0]));
            end
            seen_fin = (done === 1'b1);
        end
        start    = 1'b0;
        fin_edge = cyc;

        check({tag, " finished"}, 32'(seen_fin), 32'd1);
        check({tag, " busy_in_fin"}, 32'(busy), 32'd0);
        check({tag, " word_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            if (mode == 0) check($sformatf("%s edge%0d", tag, i), 32'(got_edge[i]), 32'(e0 + 3 + i));
        end
        if (got_q.size() > 0) begin
            last = got_edge[got_edge.size() - 1];
            check({tag, " done_after_last"}, 32'(fin_edge), 32'(last));
        end else if (ln == '0) begin
            check({tag, " done_after_accept"}, 32'(fin_edge), 32'(e0));
        end
    endtask

    task automatic idle_tick(input string tag);
        tick();
        check({tag, " done_pulse_end"}, 32'(done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " idle_valid"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        len        = '0;
        m_ready    = 1'b1;
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = 8'(8'hA0 + i);
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset m_valid", 32'(m_valid), 32'd0);
        check("reset m_data", 32'(m_data), 32'd0);
        check("reset rom_addr", 32'(rom_addr), 32'd0);
        rst = 1'b0;
        tick();

        run_burst(4'd3, 5'd5, 0, "basic");       idle_tick("basic");
        run_burst(4'd14, 5'd4, 0, "wrap4");      idle_tick("wrap4");
        run_burst(4'd0, 5'd20, 0, "wrap20");     idle_tick("wrap20");
        run_burst(4'd6, 5'd10, 1, "backpress");  idle_tick("backpress");
        run_burst(4'd9, 5'd0, 0, "len0");        idle_tick("len0");
        run_burst(4'd5, 5'd6, 3, "ign_start");   idle_tick("ign_start");

        // Reset landing on the edge of the third transfer
        got_q      = {};
        got_edge   = {};
        start_addr = 4'd9;
        len        = 5'd8;
        m_ready    = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (got_q.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        check("midrst two_words_before", 32'(got_q.size()), 32'd2);
        rst = 1'b1;
        tick();
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst m_valid", 32'(m_valid), 32'd0);
        check("midrst m_data", 32'(m_data), 32'd0);
        check("midrst rom_addr", 32'(rom_addr), 32'd0);
        rst = 1'b0;
        run_burst(4'd0, 5'd2, 0, "post_rst");    idle_tick("post_rst");

        // Second start issued during the FIN cycle of the first
        run_burst(4'd2, 5'd3, 0, "b2b_a");
        run_burst(4'd10, 5'd4, 0, "b2b_b");      idle_tick("b2b_b");

        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < DEPTH; i++) rom_mem[i] = 8'($urandom);
            tick();
            run_burst(4'($urandom_range(0, DEPTH - 1)), 5'($urandom_range(0, 2 * DEPTH - 1)),
                      2, $sformatf("rand%0d", k));
            idle_tick($sformatf("rand%0d", k));
        end

        check("no_overflow", 32'(ovf), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
